// File: rtl/apb_timer_slave_if.sv
// apb_timer_slave_if
//   APB bus bundle between the initiator and the timer completer.
//   Signals: PSEL, PENABLE, PWRITE, PADDR[3:0], PWDATA, PSTRB[3:0] (initiator -> completer);
//            PREADY, PRDATA, PSLVERR (completer -> initiator).
//   Modports: master (initiator side), slave (completer side).
interface apb_timer_slave_if #(
  parameter int DATA_W = 32
) ();
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [3:0]        PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [3:0]        PSTRB;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_timer_slave.sv
// apb_timer_slave
//   APB completer with a down-counting timer (reload, expiry status, level IRQ).
//   Register map: 0x0 CTRL {IRQ_EN, AUTO_RELOAD, EN}, 0x4 LOAD, 0x8 COUNT (RO), 0xC STATUS {EXP, W1C}.
//   Ports:
//     PCLK   - bus clock, rising edge
//     PRESET - asynchronous active-high reset
//     apb    - APB completer bundle (apb_timer_slave_if.slave)
//     IRQ_O  - timer interrupt, EXP & IRQ_EN
//   Parameters: WAIT_STATES (0..15) access-phase wait cycles, DATA_W register width.
//   Build option: define APB_TIMER_PSTRB_EN to honour PSTRB byte strobes on writes;
//   otherwise every write is full-word.
//
//   state | meaning
//   IDLE  | waiting for a setup phase
//   WAIT  | access phase, PREADY held low while wcnt runs down
//   RESP  | PREADY high for one cycle with PRDATA/PSLVERR
module apb_timer_slave #(
  parameter int WAIT_STATES = 1,
  parameter int DATA_W      = 32
) (
  input  logic               PCLK,
  input  logic               PRESET,
  apb_timer_slave_if.slave   apb,
  output logic               IRQ_O
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;

  // transfer captured at setup decode
  logic [1:0]        aidx_q;
  logic              write_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rhold_q;

  logic [2:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              exp_q, exp_d;

  logic              pready_q, pslverr_q;
  logic [DATA_W-1:0] prdata_q;

  logic              setup;
  logic              live_err;
  logic [DATA_W-1:0] live_rdata;
  logic              enter_resp;
  logic              commit;
  logic              expire;
  logic [1:0]        c_idx;
  logic              c_write;
  logic              c_err;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_rdata;
  logic [DATA_W-1:0] wmask;

`ifdef APB_TIMER_PSTRB_EN
  logic [3:0]        strb_q;
  logic [3:0]        c_strb;
  logic [1:0]        bsel;
`endif

  assign setup    = (state_q == S_IDLE) && apb.PSEL && !apb.PENABLE;
  assign live_err = (apb.PADDR[1:0] != 2'b00) || (apb.PWRITE && apb.PADDR[3:2] == 2'd2);

  always_comb begin
    live_rdata = '0;
    case (apb.PADDR[3:2])
      2'd0:    live_rdata = {{(DATA_W-3){1'b0}}, ctrl_q};
      2'd1:    live_rdata = load_q;
      2'd2:    live_rdata = count_q;
      default: live_rdata = {{(DATA_W-1){1'b0}}, exp_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!apb.PSEL)            state_d = S_IDLE;
        else if (wcnt_q == 4'd1)  state_d = S_RESP;
        else                      wcnt_d  = wcnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The write is applied on the edge that enters RESP rather than at setup, so an
  // initiator that drops PSEL during WAIT leaves the registers untouched. With
  // WAIT_STATES==0 that edge is the setup edge itself, hence the live/captured mux.
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign c_idx   = (state_q == S_IDLE) ? apb.PADDR[3:2] : aidx_q;
  assign c_write = (state_q == S_IDLE) ? apb.PWRITE     : write_q;
  assign c_err   = (state_q == S_IDLE) ? live_err       : err_q;
  assign c_wdata = (state_q == S_IDLE) ? apb.PWDATA     : wdata_q;
  assign c_rdata = (state_q == S_IDLE) ? live_rdata     : rhold_q;
  assign commit  = enter_resp && c_write && !c_err;

`ifdef APB_TIMER_PSTRB_EN
  assign c_strb = (state_q == S_IDLE) ? apb.PSTRB : strb_q;
  always_comb begin
    wmask = '0;
    bsel  = 2'd0;
    for (int i = 0; i < DATA_W; i++) begin
      bsel     = (i >= 24) ? 2'd3 : 2'(i / 8);
      wmask[i] = c_strb[bsel];
    end
  end
`else
  assign wmask = '1;
`endif

  assign expire = ctrl_q[0] && (count_q == '0);

  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    if (ctrl_q[0]) begin
      if (count_q != '0)   count_d = count_q - DATA_W'(1);
      else if (ctrl_q[1])  count_d = load_q;
      else                 ctrl_d[0] = 1'b0;
    end
    // bus writes override the timer's own update in the same cycle
    if (commit) begin
      case (c_idx)
        2'd0: ctrl_d = (ctrl_q & ~wmask[2:0]) | (c_wdata[2:0] & wmask[2:0]);
        2'd1: begin
          load_d  = (load_q & ~wmask) | (c_wdata & wmask);
          count_d = load_d;
        end
        2'd3: if (c_wdata[0] && wmask[0]) exp_d = 1'b0;
        default: ;
      endcase
    end
    // expiry set beats a simultaneous W1C
    if (expire) exp_d = 1'b1;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      aidx_q    <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      rhold_q   <= '0;
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      exp_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
`ifdef APB_TIMER_PSTRB_EN
      strb_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      exp_q     <= exp_d;
      if (setup) begin
        aidx_q  <= apb.PADDR[3:2];
        write_q <= apb.PWRITE;
        err_q   <= live_err;
        wdata_q <= apb.PWDATA;
        rhold_q <= live_rdata;
`ifdef APB_TIMER_PSTRB_EN
        strb_q  <= apb.PSTRB;
`endif
      end
      pready_q  <= enter_resp;
      pslverr_q <= enter_resp && c_err;
      prdata_q  <= (enter_resp && !c_err && !c_write) ? c_rdata : '0;
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = prdata_q;
  assign IRQ_O       = exp_q && ctrl_q[2];

endmodule
